mod_counter_load: RTL and testbench
===================================

Name: mod_counter_load

Overview:
- Parametrised modulo-N up/down counter for the clock datapath: seconds, minutes, hours and day fields.
- Supports synchronous preset from switches, range-checked load, synchronous clear and hold.
- Provides a combinational terminal-count output so stages cascade in the same cycle (sec -> min -> hour).
- Replaces the fixed 6-bit minute counter with its asynchronous set. Preset is now synchronous, so the only asynchronous control is reset.

Parameters:
- WIDTH, 6, counter and load width in bits; must satisfy 2**WIDTH >= MODULUS.
- MODULUS, 60, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- RESET_VAL, 0, value of Q after reset and after clear; must be < MODULUS.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- rst_neg  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear to RESET_VAL.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  preset value, e.g. from switches.
- en  in  1  count enable; cascade input fed from the previous stage's tc.
- up_dn  in  1  1 = count up, 0 = count down.
- Q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational; cascade output.
- load_err  out  1  registered one-cycle pulse when a load is out of range.

Behaviour:
- Reset: rst_neg low -> Q = RESET_VAL and load_err = 0 immediately, independent of clock. tc follows its equation. Release is synchronous to the next rising edge; the first count occurs at the first edge with rst_neg high.
- Priority at each rising edge: clr > load > en > hold.
- clr=1: Q <= RESET_VAL; load_err <= 0.
- load=1 (clr=0), load_val < MODULUS: Q <= load_val; load_err <= 0.
- load=1 (clr=0), load_val >= MODULUS: Q <= 0; load_err <= 1 for exactly one cycle.
- Count up (en=1, up_dn=1): Q <= Q+1; when Q == MODULUS-1, Q <= 0 (wrap).
- Count down (en=1, up_dn=0): Q <= Q-1; when Q == 0, Q <= MODULUS-1 (wrap).
- Hold: en=0 with no clr/load -> Q unchanged.
- load_err is 0 in every cycle without an out-of-range load.
- tc = en & ~clr & ~load & (up_dn ? Q == MODULUS-1 : Q == 0).
  - tc is high in the cycle before the wrap edge, so the next stage's en = tc advances on the same edge as the wrap.
  - tc is never high during clr or load.
- Q never leaves 0..MODULUS-1, including after any load, any up_dn change or reset mid-count.
- Width rule: comparisons are unsigned at WIDTH bits. With MODULUS == 2**WIDTH the wrap equals natural overflow and must not produce an X or an extra state.
- up_dn changing while en=1 takes effect at that edge. tc is recomputed combinationally in the same cycle.
- Latency: load, clr and count take effect at Q one edge after being sampled. tc has zero latency from Q, en and up_dn.

Decomposition:
- Package clock_pkg:
  - SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24, DAY_MOD=7.
  - Matching widths SEC_W=6, MIN_W=6, HOUR_W=5, DAY_W=3.
  - Function clog2 for deriving WIDTH from MODULUS.
- No sub-module inside the block.
- Chains are built one level up: a clock_chain top instantiates three mod_counter_load stages, wiring tc -> en.

Test Plan (WIDTH=6, MODULUS=60, RESET_VAL=0 unless stated):
- Reset: drive rst_neg low mid-count at Q=37, between clock edges -> Q=0 immediately; load_err=0. After release, en=1 up -> Q reads 1 after the first edge.
- Up wrap: load 58, then en=1 up_dn=1 for 3 edges -> Q = 59, 0, 1. tc=1 only while Q=59. A cascaded second instance with en=tc increments exactly once.
- Down wrap: load 1, up_dn=0, en=1 for 3 edges -> Q = 0, 59, 58. tc=1 only while Q=0.
- Range check: load 59 -> Q=59, load_err=0. Load 60 -> Q=0, load_err=1 for one cycle. Load 63 -> Q=0, load_err pulses again. Confirm tc=0 in all load cycles.
- Priority: clr=1, load=1 (val 20), en=1 together -> Q=RESET_VAL, tc=0. Then load=1 with en=1 at Q=59 up -> Q=20, no tc.
- Full-range and hold: WIDTH=3, MODULUS=8, RESET_VAL=5 -> after reset Q=5; count up 3 edges -> Q = 6, 7, 0. With en=0 for 4 edges, Q holds 0 and tc=0.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared constants for the clock datapath (seconds, minutes,
//               hours, day-of-week) and a width helper used to size
//               modulo counters from their modulus.
// Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    // Field moduli
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;
    localparam int DAY_MOD  = 7;

    // Matching field widths
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 3;

    // Smallest w with 2**w >= value. Written as a bounded loop so it is
    // usable in constant (parameter) expressions.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/mod_counter_load_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_load_if
// Description : Control/status bundle of one modulo counter stage.
//               master : the controlling logic (drives clr/load/en/up_dn,
//                        observes Q/tc/load_err)
//               slave  : the counter itself
// Signals     : clr, load, load_val[WIDTH], en, up_dn  (master -> slave)
//               Q[WIDTH], tc, load_err                 (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface mod_counter_load_if
    import clock_pkg::*;
#(
    parameter int WIDTH = SEC_W
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             load_err;

    modport master (
        output clr, load, load_val, en, up_dn,
        input  Q, tc, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up_dn,
        output Q, tc, load_err
    );

endinterface : mod_counter_load_if
`default_nettype wire

// File: rtl/mod_counter_load.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_load
// Description : Modulo-MODULUS up/down counter with synchronous clear,
//               range-checked synchronous load and hold. The terminal count
//               is combinational so that a chain of stages (tc -> en) all
//               advance on the same edge.
// Ports       : clock     system clock, rising edge active
//               rst_neg   asynchronous active-low reset
//               bus       mod_counter_load_if.slave
//                         clr/load/load_val/en/up_dn in, Q/tc/load_err out
// Parameters  : WIDTH     counter width, 2**WIDTH >= MODULUS
//               MODULUS   count range 0..MODULUS-1, 2..2**WIDTH
//               RESET_VAL value after reset and clear, < MODULUS
// Revision    : 1.0  initial release (replaces fixed minute counter with
//                    asynchronous set; preset is now synchronous)
// ============================================================================
module mod_counter_load
    import clock_pkg::*;
#(
    parameter int WIDTH     = clog2(SEC_MOD),
    parameter int MODULUS   = SEC_MOD,
    parameter int RESET_VAL = 0
) (
    input  wire logic        clock,
    input  wire logic        rst_neg,
    mod_counter_load_if.slave bus
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_RST = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0]   c_MOD = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_load_err;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_q_next;
    logic             w_err_next;

    assign w_at_max  = (r_q == c_MAX);
    assign w_at_zero = (r_q == '0);
    assign w_load_ok = ({1'b0, bus.load_val} < c_MOD);

    // Priority clr > load > en > hold. Wrap is an explicit compare against
    // MODULUS-1 / 0, so the full-range case (MODULUS == 2**WIDTH) gives the
    // same result as natural overflow without relying on it.
    always_comb begin
        w_q_next   = r_q;
        w_err_next = 1'b0;
        if (bus.clr) begin
            w_q_next = c_RST;
        end else if (bus.load) begin
            if (w_load_ok) begin
                w_q_next = bus.load_val;
            end else begin
                w_q_next   = '0;
                w_err_next = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                w_q_next = w_at_max ? '0 : (r_q + c_ONE);
            end else begin
                w_q_next = w_at_zero ? c_MAX : (r_q - c_ONE);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_neg) begin
        if (!rst_neg) begin
            r_q        <= c_RST;
            r_load_err <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_load_err <= w_err_next;
        end
    end

    // Terminal count: high in the cycle before a wrap edge, suppressed
    // whenever clr or load overrides counting.
    assign bus.tc       = bus.en & ~bus.clr & ~bus.load &
                          (bus.up_dn ? w_at_max : w_at_zero);
    assign bus.Q        = r_q;
    assign bus.load_err = r_load_err;

endmodule : mod_counter_load
`default_nettype wire

// File: tb/tb_mod_counter_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter_load
// Description : Self-checking bench for mod_counter_load. Stage a is a
//               60-count counter, stage b is cascaded from a (en = a.tc),
//               stage s is a full-range 3-bit counter with RESET_VAL 5.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_counter_load;
    import clock_pkg::*;

    logic clock;
    logic rst_neg;
    int   n_tests;
    int   n_fail;

    mod_counter_load_if #(.WIDTH(6)) a_if ();
    mod_counter_load_if #(.WIDTH(6)) b_if ();
    mod_counter_load_if #(.WIDTH(3)) s_if ();

    mod_counter_load #(.WIDTH(6), .MODULUS(SEC_MOD), .RESET_VAL(0)) u_a (
        .clock(clock), .rst_neg(rst_neg), .bus(a_if));
    mod_counter_load #(.WIDTH(6), .MODULUS(SEC_MOD), .RESET_VAL(0)) u_b (
        .clock(clock), .rst_neg(rst_neg), .bus(b_if));
    mod_counter_load #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) u_s (
        .clock(clock), .rst_neg(rst_neg), .bus(s_if));

    assign b_if.en = a_if.tc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model (plain modular arithmetic) ----------
    function automatic int mdl_next(int q, bit clr, bit load, int val,
                                    bit en, bit up, int m, int rv);
        if (clr)  return rv;
        if (load) return (val < m) ? val : 0;
        if (en)   return up ? (q + 1) % m : (q + m - 1) % m;
        return q;
    endfunction

    function automatic bit mdl_err(bit clr, bit load, int val, int m);
        return !clr && load && (val >= m);
    endfunction

    function automatic bit mdl_tc(int q, bit clr, bit load, bit en, bit up, int m);
        return en && !clr && !load && (up ? (q == m - 1) : (q == 0));
    endfunction

    // ---------------- stimulus drivers ------------------------------------
    task automatic drv_a(bit clr, bit load, int val, bit en, bit up);
        a_if.clr = clr; a_if.load = load; a_if.load_val = 6'(val);
        a_if.en = en; a_if.up_dn = up;
    endtask

    task automatic drv_s(bit clr, bit load, int val, bit en, bit up);
        s_if.clr = clr; s_if.load = load; s_if.load_val = 3'(val);
        s_if.en = en; s_if.up_dn = up;
    endtask

    // ---------------- scenarios -------------------------------------------
    task automatic test_reset;
        n_tests++;
        if (a_if.Q !== 6'd0 || a_if.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: Q=%0d err=%b, want Q=0 err=0", a_if.Q, a_if.load_err);
        end
        n_tests++;
        if (s_if.Q !== 3'd5) begin
            n_fail++;
            $display("FAIL reset_s: Q=%0d, want 5", s_if.Q);
        end
        @(negedge clock);
        rst_neg = 1'b1;
        drv_a(0, 1, 37, 0, 1);
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd37) begin
            n_fail++;
            $display("FAIL reset_preload: Q=%0d, want 37", a_if.Q);
        end
        #2 rst_neg = 1'b0;
        #1;
        n_tests++;
        if (a_if.Q !== 6'd0 || a_if.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: Q=%0d err=%b, want Q=0 err=0", a_if.Q, a_if.load_err);
        end
        @(negedge clock);
        rst_neg = 1'b1;
        drv_a(0, 0, 0, 1, 1);
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd1) begin
            n_fail++;
            $display("FAIL reset_first_count: Q=%0d, want 1", a_if.Q);
        end
    endtask

    task automatic test_up_wrap;
        int exp_q [3]  = '{59, 0, 1};
        bit exp_tc [3] = '{1'b0, 1'b1, 1'b0};
        int exp_b [3]  = '{0, 1, 1};
        @(negedge clock);
        drv_a(0, 1, 58, 0, 1);
        b_if.clr = 1'b1;
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd58 || b_if.Q !== 6'd0) begin
            n_fail++;
            $display("FAIL up_load: a.Q=%0d b.Q=%0d, want 58 0", a_if.Q, b_if.Q);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            b_if.clr = 1'b0;
            drv_a(0, 0, 0, 1, 1);
            #1;
            n_tests++;
            if (a_if.tc !== exp_tc[i]) begin
                n_fail++;
                $display("FAIL up_tc[%0d]: tc=%b, want %b", i, a_if.tc, exp_tc[i]);
            end
            @(posedge clock); #1;
            n_tests++;
            if (a_if.Q !== 6'(exp_q[i]) || b_if.Q !== 6'(exp_b[i])) begin
                n_fail++;
                $display("FAIL up_q[%0d]: a.Q=%0d b.Q=%0d, want %0d %0d",
                         i, a_if.Q, b_if.Q, exp_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_down_wrap;
        int exp_q [3]  = '{0, 59, 58};
        bit exp_tc [3] = '{1'b0, 1'b1, 1'b0};
        @(negedge clock);
        drv_a(0, 1, 1, 0, 0);
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd1) begin
            n_fail++;
            $display("FAIL down_load: Q=%0d, want 1", a_if.Q);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drv_a(0, 0, 0, 1, 0);
            #1;
            n_tests++;
            if (a_if.tc !== exp_tc[i]) begin
                n_fail++;
                $display("FAIL down_tc[%0d]: tc=%b, want %b", i, a_if.tc, exp_tc[i]);
            end
            @(posedge clock); #1;
            n_tests++;
            if (a_if.Q !== 6'(exp_q[i])) begin
                n_fail++;
                $display("FAIL down_q[%0d]: Q=%0d, want %0d", i, a_if.Q, exp_q[i]);
            end
        end
    endtask

    task automatic test_range;
        int vals [3]    = '{59, 60, 63};
        int exp_q [3]   = '{59, 0, 0};
        bit exp_err [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drv_a(0, 1, vals[i], 1, 1);
            #1;
            n_tests++;
            if (a_if.tc !== 1'b0) begin
                n_fail++;
                $display("FAIL range_tc[%0d]: tc=%b, want 0", i, a_if.tc);
            end
            @(posedge clock); #1;
            n_tests++;
            if (a_if.Q !== 6'(exp_q[i]) || a_if.load_err !== exp_err[i]) begin
                n_fail++;
                $display("FAIL range_load[%0d]: Q=%0d err=%b, want %0d %b",
                         i, a_if.Q, a_if.load_err, exp_q[i], exp_err[i]);
            end
            @(negedge clock);
            drv_a(0, 0, 0, 0, 1);
            @(posedge clock); #1;
            n_tests++;
            if (a_if.Q !== 6'(exp_q[i]) || a_if.load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL range_pulse[%0d]: Q=%0d err=%b, want %0d 0",
                         i, a_if.Q, a_if.load_err, exp_q[i]);
            end
        end
    endtask

    task automatic test_priority;
        @(negedge clock);
        drv_a(1, 1, 20, 1, 1);
        #1;
        n_tests++;
        if (a_if.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_clr_tc: tc=%b, want 0", a_if.tc);
        end
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd0 || a_if.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_clr: Q=%0d err=%b, want 0 0", a_if.Q, a_if.load_err);
        end
        @(negedge clock);
        drv_a(0, 1, 59, 0, 1);
        @(posedge clock); #1;
        @(negedge clock);
        drv_a(0, 1, 20, 1, 1);
        #1;
        n_tests++;
        if (a_if.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_load_tc: tc=%b, want 0", a_if.tc);
        end
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd20 || a_if.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_load: Q=%0d err=%b, want 20 0", a_if.Q, a_if.load_err);
        end
        @(negedge clock);
        drv_a(1, 1, 63, 0, 1);
        @(posedge clock); #1;
        n_tests++;
        if (a_if.Q !== 6'd0 || a_if.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_clr_badload: Q=%0d err=%b, want 0 0", a_if.Q, a_if.load_err);
        end
    endtask

    task automatic test_full_range_hold;
        int exp_q [7]  = '{6, 7, 0, 0, 0, 0, 0};
        bit exp_tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge clock);
        drv_s(1, 0, 0, 0, 1);
        @(posedge clock); #1;
        n_tests++;
        if (s_if.Q !== 3'd5) begin
            n_fail++;
            $display("FAIL small_clr: Q=%0d, want 5", s_if.Q);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            drv_s(0, 0, 0, (i < 3) ? 1'b1 : 1'b0, 1);
            #1;
            n_tests++;
            if (s_if.tc !== exp_tc[i]) begin
                n_fail++;
                $display("FAIL small_tc[%0d]: tc=%b, want %b", i, s_if.tc, exp_tc[i]);
            end
            @(posedge clock); #1;
            n_tests++;
            if (s_if.Q !== 3'(exp_q[i])) begin
                n_fail++;
                $display("FAIL small_q[%0d]: Q=%0d, want %0d", i, s_if.Q, exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int mq_a;
        int mq_s;
        bit ea;
        bit es;
        bit c_a, l_a, e_a, u_a;
        bit c_s, l_s, e_s, u_s;
        int v_a, v_s;
        mq_a = 0;
        mq_s = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            c_a = (i == 0) || ($urandom_range(0, 15) == 0);
            l_a = ($urandom_range(0, 7) == 0);
            v_a = int'($urandom_range(0, 63));
            e_a = ($urandom_range(0, 3) != 0);
            u_a = 1'($urandom_range(0, 1));
            c_s = (i == 0) || ($urandom_range(0, 15) == 0);
            l_s = ($urandom_range(0, 7) == 0);
            v_s = int'($urandom_range(0, 7));
            e_s = ($urandom_range(0, 3) != 0);
            u_s = 1'($urandom_range(0, 1));
            drv_a(c_a, l_a, v_a, e_a, u_a);
            drv_s(c_s, l_s, v_s, e_s, u_s);
            #1;
            if (i > 0) begin
                n_tests++;
                if (a_if.tc !== mdl_tc(mq_a, c_a, l_a, e_a, u_a, 60) ||
                    s_if.tc !== mdl_tc(mq_s, c_s, l_s, e_s, u_s, 8)) begin
                    n_fail++;
                    $display("FAIL rand_tc[%0d]: a.tc=%b s.tc=%b, want %b %b", i,
                             a_if.tc, s_if.tc, mdl_tc(mq_a, c_a, l_a, e_a, u_a, 60),
                             mdl_tc(mq_s, c_s, l_s, e_s, u_s, 8));
                end
            end
            ea   = mdl_err(c_a, l_a, v_a, 60);
            es   = mdl_err(c_s, l_s, v_s, 8);
            mq_a = mdl_next(mq_a, c_a, l_a, v_a, e_a, u_a, 60, 0);
            mq_s = mdl_next(mq_s, c_s, l_s, v_s, e_s, u_s, 8, 5);
            @(posedge clock); #1;
            n_tests++;
            if (a_if.Q !== 6'(mq_a) || a_if.load_err !== ea ||
                s_if.Q !== 3'(mq_s) || s_if.load_err !== es) begin
                n_fail++;
                $display("FAIL rand_q[%0d]: a=%0d/%b s=%0d/%b, want %0d/%b %0d/%b", i,
                         a_if.Q, a_if.load_err, s_if.Q, s_if.load_err, mq_a, ea, mq_s, es);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_neg = 1'b1;
        drv_a(0, 0, 0, 0, 1);
        drv_s(0, 0, 0, 0, 1);
        b_if.clr = 1'b0; b_if.load = 1'b0; b_if.load_val = '0; b_if.up_dn = 1'b1;
        #2 rst_neg = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_range();
        test_priority();
        test_full_range_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mod_counter_load
`default_nettype wire
